// File: rtl/imm_gen_pipe.sv
// Elastic RV immediate generator: format extraction into stage 0, then STAGES
// valid/ready register stages with flush, pass-through tag and illegal-select counter.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;
  logic [XLEN-1:0]    ext;
  logic               ext_ill;
  logic               unused_instr;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign unused_instr = ^instr[6:0];

  // Signed sources sign-extend through the size cast; shamt and zimm are unsigned.
  always_comb begin
    ext     = '0;
    ext_ill = 1'b0;
    case (sel)
      3'd0: ext = XLEN'(imm_i);
      3'd1: ext = XLEN'(imm_s);
      3'd2: ext = XLEN'(imm_b);
      3'd3: ext = XLEN'(imm_j);
      3'd4: ext = XLEN'(imm_u);
      3'd5: ext = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      3'd6: ext = XLEN'(instr[19:15]);
      default: begin
        ext     = '0;
        ext_ill = 1'b1;
      end
    endcase
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] up_vld;
  logic [STAGES-1:0] up_ill;
  logic [STAGES-1:0] s_ill;
  logic [XLEN-1:0]   up_imm [STAGES];
  logic [XLEN-1:0]   s_imm  [STAGES];
  logic [TAG_W-1:0]  up_tag [STAGES];
  logic [TAG_W-1:0]  s_tag  [STAGES];

  // A stage may load when it or any stage downstream of it has a hole, or the output drains.
  for (genvar i = 0; i < STAGES; i++) begin : g_link
    assign go[i] = out_ready | ~&vld[STAGES-1:i];
    if (i == 0) begin : g_head
      assign up_vld[i] = in_valid;
      assign up_imm[i] = ext;
      assign up_tag[i] = in_tag;
      assign up_ill[i] = ext_ill;
    end else begin : g_body
      assign up_vld[i] = vld[i-1];
      assign up_imm[i] = s_imm[i-1];
      assign up_tag[i] = s_tag[i-1];
      assign up_ill[i] = s_ill[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld   <= '0;
      s_ill <= '0;
      for (int i = 0; i < STAGES; i++) begin
        s_imm[i] <= '0;
        s_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush) begin
          vld[i] <= 1'b0;
        end else if (go[i]) begin
          vld[i] <= up_vld[i];
        end
        if (!flush && go[i] && up_vld[i]) begin
          s_imm[i] <= up_imm[i];
          s_tag[i] <= up_tag[i];
          s_ill[i] <= up_ill[i];
        end
      end
    end
  end

  assign in_ready    = !flush & go[0];
  assign out_valid   = vld[STAGES-1];
  assign imm         = s_imm[STAGES-1];
  assign out_tag     = s_tag[STAGES-1];
  assign out_illegal = s_ill[STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_cnt <= '0;
    end else if (in_valid && in_ready && ext_ill && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit single-stage and a 64-bit three-stage instance,
// each with a scoreboard queue filled on acceptance and drained by an output monitor.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [31:0] a_instr = 0;
  logic [2:0]  a_sel = 0;
  logic [4:0]  a_in_tag = 0, a_out_tag;
  logic [31:0] a_imm;
  logic        a_out_illegal;
  logic [7:0]  a_cnt;

  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [31:0] b_instr = 0;
  logic [2:0]  b_sel = 0;
  logic [4:0]  b_in_tag = 0, b_out_tag;
  logic [63:0] b_imm;
  logic        b_out_illegal;
  logic [7:0]  b_cnt;

  exp_t qa[$];
  exp_t qb[$];

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .sel(a_sel), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .imm(a_imm), .out_tag(a_out_tag), .out_illegal(a_out_illegal),
    .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .sel(b_sel), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .imm(b_imm), .out_tag(b_out_tag), .out_illegal(b_out_illegal),
    .illegal_cnt(b_cnt));

  // Reference extraction built from arithmetic right shifts of left-aligned fields.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] s, input int xl);
    logic signed [63:0] t;
    t = 64'sd0;
    case (s)
      3'd0: begin t = $signed({ins[31:20], 52'b0}); t = t >>> 52; end
      3'd1: begin t = $signed({ins[31:25], ins[11:7], 52'b0}); t = t >>> 52; end
      3'd2: begin t = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0}); t = t >>> 51; end
      3'd3: begin t = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0}); t = t >>> 43; end
      3'd4: begin t = $signed({ins[31:12], 12'b0, 32'b0}); t = t >>> 32; end
      3'd5: t = (xl == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      3'd6: t = {59'b0, ins[19:15]};
      default: t = 64'sd0;
    endcase
    if (xl == 32) return {32'b0, t[31:0]};
    return t;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_output tag=%0d imm=%h", a_out_tag, a_imm);
      end else begin
        e = qa.pop_front();
        if (a_imm !== e.imm[31:0] || a_out_tag !== e.tag || a_out_illegal !== e.ill) begin
          errors++;
          $display("FAIL a_output got imm=%h tag=%0d ill=%b want imm=%h tag=%0d ill=%b",
                   a_imm, a_out_tag, a_out_illegal, e.imm[31:0], e.tag, e.ill);
        end
      end
    end
    if (b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_output tag=%0d imm=%h", b_out_tag, b_imm);
      end else begin
        e = qb.pop_front();
        if (b_imm !== e.imm || b_out_tag !== e.tag || b_out_illegal !== e.ill) begin
          errors++;
          $display("FAIL b_output got imm=%h tag=%0d ill=%b want imm=%h tag=%0d ill=%b",
                   b_imm, b_out_tag, b_out_illegal, e.imm, e.tag, e.ill);
        end
      end
    end
  end

  task automatic send_a(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] tg,
                        input logic [63:0] ex);
    exp_t e;
    e.imm = ex; e.tag = tg; e.ill = (s == 3'd7);
    a_instr = ins; a_sel = s; a_in_tag = tg; a_in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_a_timeout in_ready=%b want 1", a_in_ready);
  endtask

  task automatic send_b(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] tg,
                        input logic [63:0] ex);
    exp_t e;
    e.imm = ex; e.tag = tg; e.ill = (s == 3'd7);
    b_instr = ins; b_sel = s; b_in_tag = tg; b_in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_b_timeout in_ready=%b want 1", b_in_ready);
  endtask

  task automatic drain;
    for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain pending a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (a_out_valid !== 1'b0 || a_imm !== 32'h0 || a_out_tag !== 5'h0 || a_out_illegal !== 1'b0 || a_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_a got v=%b imm=%h tag=%0d ill=%b cnt=%0d want all 0",
               a_out_valid, a_imm, a_out_tag, a_out_illegal, a_cnt);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_imm !== 64'h0 || b_out_tag !== 5'h0 || b_out_illegal !== 1'b0 || b_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_b got v=%b imm=%h tag=%0d ill=%b cnt=%0d want all 0",
               b_out_valid, b_imm, b_out_tag, b_out_illegal, b_cnt);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got a=%b b=%b want 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_formats32;
    logic [31:0] ins;
    logic [2:0]  s;
    a_out_ready = 1'b1;
    send_a(32'hFFF00093, 3'd0, 5'd1, 64'hFFFFFFFF);
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL a_latency out_valid=%b want 1", a_out_valid);
    end
    send_a(32'hFE112E23, 3'd1, 5'd2, 64'hFFFFFFFC);
    send_a(32'hFE000CE3, 3'd2, 5'd3, 64'hFFFFFFF8);
    send_a(32'h0010006F, 3'd3, 5'd4, 64'h00000800);
    send_a(32'h123450B7, 3'd4, 5'd5, 64'h12345000);
    send_a(32'h01F0D093, 3'd5, 5'd6, 64'h0000001F);
    send_a(32'h000FD073, 3'd6, 5'd7, 64'h0000001F);
    for (int k = 0; k < 24; k++) begin
      ins = $urandom;
      s = 3'($urandom_range(0, 7));
      send_a(ins, s, 5'(k), model(ins, s, 32));
    end
    a_in_valid = 1'b0;
    drain();
  endtask

  task automatic test_formats64;
    logic [31:0] ins;
    logic [2:0]  s;
    b_out_ready = 1'b1;
    send_b(32'h800000B7, 3'd4, 5'd9, 64'hFFFFFFFF80000000);
    b_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (b_out_valid !== (c == 2)) begin
        errors++;
        $display("FAIL b_latency step=%0d out_valid=%b want %b", c, b_out_valid, (c == 2));
      end
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    send_b(32'h03F0D093, 3'd5, 5'd10, 64'h000000000000003F);
    for (int k = 0; k < 24; k++) begin
      ins = $urandom;
      s = 3'($urandom_range(0, 6));
      send_b(ins, s, 5'(k), model(ins, s, 64));
    end
    b_in_valid = 1'b0;
    drain();
  endtask

  task automatic test_stall;
    int idx;
    logic [63:0] held;
    exp_t e;
    idx = 0;
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      b_in_valid = (idx < 6);
      b_sel = 3'd0;
      b_instr = $urandom | 32'h8000_0000;
      b_in_tag = 5'(idx);
      b_out_ready = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      if (cyc >= 3 && cyc <= 7) begin
        checks++;
        if (b_in_ready !== 1'b0 || idx != 3) begin
          errors++;
          $display("FAIL stall_in_ready cyc=%0d in_ready=%b accepted=%0d want 0 and 3", cyc, b_in_ready, idx);
        end
        if (cyc == 3) held = b_imm;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_tag !== 5'd0 || b_imm !== held) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d v=%b tag=%0d imm=%h want 1 0 %h", cyc, b_out_valid, b_out_tag, b_imm, held);
        end
      end
      if (b_in_valid && b_in_ready) begin
        e.imm = model(b_instr, 3'd0, 64); e.tag = 5'(idx); e.ill = 1'b0;
        qb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL stall_accepted got %0d want 6", idx);
    end
    drain();
  endtask

  task automatic test_illegal;
    int idx;
    int exp_cnt;
    exp_t e;
    idx = 0;
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && idx < 300; cyc++) begin
      b_in_valid = 1'b1;
      b_sel = 3'd7;
      b_instr = $urandom;
      b_in_tag = 5'(idx);
      b_flush = (cyc == 150);
      @(negedge clk);
      if (b_flush) begin
        checks++;
        if (b_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_in_ready got %b want 0", b_in_ready);
        end
      end
      if (b_in_valid && b_in_ready) begin
        e.imm = 64'h0; e.tag = 5'(idx); e.ill = 1'b1;
        qb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      if (b_flush) begin
        qb.delete();
        b_flush = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_out_valid got %b want 0", b_out_valid);
        end
      end
      exp_cnt = (idx > 255) ? 255 : idx;
      checks++;
      if (b_cnt !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL illegal_cnt got %0d want %0d", b_cnt, exp_cnt);
      end
    end
    b_in_valid = 1'b0;
    drain();
    checks++;
    if (b_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_cnt_sat got %0d want 255", b_cnt);
    end
  endtask

  task automatic test_reset_midstall;
    b_out_ready = 1'b0;
    send_b(32'h8765_4000, 3'd4, 5'd21, 64'hFFFFFFFF87654000);
    send_b(32'h1234_5000, 3'd4, 5'd22, 64'h0000000012345000);
    send_b(32'hFFF0_0000, 3'd0, 5'd23, 64'hFFFFFFFFFFFFFFFF);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_out_tag !== 5'd21) begin
      errors++;
      $display("FAIL midstall_full v=%b in_ready=%b tag=%0d want 1 0 21", b_out_valid, b_in_ready, b_out_tag);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_imm !== 64'h0 || b_out_tag !== 5'h0 || b_out_illegal !== 1'b0 || b_cnt !== 8'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b imm=%h tag=%0d ill=%b cnt=%0d want all 0",
               b_out_valid, b_imm, b_out_tag, b_out_illegal, b_cnt);
    end
    qb.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready got %b want 1", b_in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (b_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_entry cyc=%0d out_valid=%b want 0", c, b_out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_formats64();
    test_stall();
    test_illegal();
    test_reset_midstall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
